// File: rtl/mux_arb_stream_if.sv
// Stream bundle for mux_arb_stream: N packed input channels in, one registered channel out.
// The master side is the traffic source/sink; the slave side is the arbiter itself.
interface mux_arb_stream_if #(
    parameter int W  = 4,
    parameter int N  = 4,
    parameter int SW = 2
) ();
    logic [N*W-1:0] A;
    logic [N-1:0]   AVld;
    logic [N-1:0]   ARdy;
    logic           Mode;
    logic [W-1:0]   C;
    logic           CVld;
    logic           CRdy;
    logic [SW-1:0]  S;
    logic [7:0]     XferCnt;

    modport master (
        output A, AVld, Mode, CRdy,
        input  ARdy, C, CVld, S, XferCnt
    );

    modport slave (
        input  A, AVld, Mode, CRdy,
        output ARdy, C, CVld, S, XferCnt
    );
endinterface

// File: rtl/mux_arb_stream.sv
// N-to-1 stream arbiter/mux with fixed-priority or round-robin grant and a single
// registered output stage that sustains one word per cycle under continuous ready.
module mux_arb_stream #(
    parameter int W  = 4,
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic               Clk,
    input  logic               Rst,
    mux_arb_stream_if.slave    bus
);
    logic [W-1:0]  c_q, c_d;
    logic [SW-1:0] s_q, s_d;
    logic          cvld_q, cvld_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [7:0]    cnt_q, cnt_d;

    logic          grant_vld_s;
    logic [SW-1:0] grant_idx_s;
    logic [W-1:0]  grant_data_s;
    logic          accept_s;
    logic          in_xfer_s;
    logic          out_xfer_s;
    int            idx_s;

    // Grant search: Mode 0 starts at channel 0, Mode 1 starts at Ptr and wraps.
    always_comb begin
        grant_vld_s  = 1'b0;
        grant_idx_s  = '0;
        grant_data_s = '0;
        idx_s        = 0;
        for (int k = 0; k < N; k++) begin
            if (bus.Mode) begin
                idx_s = int'(ptr_q) + k;
                if (idx_s >= N) begin
                    idx_s = idx_s - N;
                end else begin
                    idx_s = idx_s;
                end
            end else begin
                idx_s = k;
            end
            if (!grant_vld_s && bus.AVld[idx_s]) begin
                grant_vld_s  = 1'b1;
                grant_idx_s  = SW'(idx_s);
                grant_data_s = bus.A[idx_s*W +: W];
            end else begin
                grant_vld_s  = grant_vld_s;
            end
        end
    end

    // Handshake decode and next-state for the output register, pointer and counter.
    always_comb begin
        accept_s   = !cvld_q || bus.CRdy;
        in_xfer_s  = grant_vld_s && accept_s && !Rst;
        out_xfer_s = cvld_q && bus.CRdy;
        c_d        = c_q;
        s_d        = s_q;
        cvld_d     = cvld_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        if (out_xfer_s) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
        if (in_xfer_s) begin
            c_d    = grant_data_s;
            s_d    = grant_idx_s;
            cvld_d = 1'b1;
            if (bus.Mode) begin
                // Explicit wrap so non-power-of-two N never leaves Ptr out of range.
                ptr_d = (grant_idx_s == SW'(N - 1)) ? SW'(0) : grant_idx_s + SW'(1);
            end else begin
                ptr_d = ptr_q;
            end
        end else if (out_xfer_s) begin
            cvld_d = 1'b0;
        end else begin
            cvld_d = cvld_q;
        end
    end

    // Ready goes only to the granted channel, and only while the output can take a word.
    always_comb begin
        bus.ARdy = '0;
        if (in_xfer_s) begin
            bus.ARdy[grant_idx_s] = 1'b1;
        end else begin
            bus.ARdy = '0;
        end
    end

    // State registers with synchronous reset overriding any transfer in the same cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            c_q    <= '0;
            s_q    <= '0;
            cvld_q <= 1'b0;
            ptr_q  <= '0;
            cnt_q  <= 8'd0;
        end else begin
            c_q    <= c_d;
            s_q    <= s_d;
            cvld_q <= cvld_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.C       = c_q;
    assign bus.S       = s_q;
    assign bus.CVld    = cvld_q;
    assign bus.XferCnt = cnt_q;
endmodule

// File: doc/mux_arb_stream.md
MUX_ARB_STREAM -- requirements
Module: mux_arb_stream

Interface
- REQ-001 SHALL have parameter W, default 4, data width per channel (W >= 1).
- REQ-002 SHALL have parameter N, default 4, number of input channels (N >= 2).
- REQ-003 SHALL have parameter SW, default 2, select width = clog2(N).
- REQ-004 SHALL have one clock and a synchronous, active-high reset: Clk  input  1  rising-edge clock.
- REQ-005 SHALL have Rst  input  1  synchronous active-high reset.
- REQ-006 SHALL have A  input  N*W  packed channel data; channel i = A[i*W+W-1 : i*W].
- REQ-007 SHALL have AVld  input  N  per-channel valid.
- REQ-008 SHALL have ARdy  output  N  per-channel ready; one-hot or zero.
- REQ-009 SHALL have Mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- REQ-010 SHALL have C  output  W  registered output data.
- REQ-011 SHALL have CVld  output  1  output holds valid data.
- REQ-012 SHALL have CRdy  input  1  downstream ready.
- REQ-013 SHALL have S  output  SW  index of the channel whose data is in C.
- REQ-014 SHALL have XferCnt  output  8  count of completed output transfers.

Function
- REQ-015 SHALL define transfer on input i as AVld[i] && ARdy[i] at a rising Clk edge; output transfer as CVld && CRdy.
- REQ-016 SHALL define accept = !CVld || CRdy (output register empty or draining this cycle).
- REQ-017 SHALL compute the grant combinationally: no AVld set -> no grant; otherwise exactly one channel.
- REQ-018 SHALL, in Mode 0, grant the lowest index i with AVld[i] = 1.
- REQ-019 SHALL, in Mode 1, grant the first i with AVld[i] = 1 found by searching Ptr, Ptr+1, ..., N-1, 0, ..., Ptr-1.
- REQ-020 SHALL drive ARdy[i] = 1 only for the granted channel and only when accept = 1; ARdy SHALL depend on no other signals.
- REQ-021 SHALL, on an input transfer from channel i, load C <= channel i data, S <= i, and CVld <= 1 at that edge (latency 1 cycle).
- REQ-022 SHALL, on an output transfer with no input transfer in the same cycle, clear CVld; C and S hold their values.
- REQ-023 SHALL, when an output transfer and an input transfer coincide, load the new data and keep CVld = 1 (full throughput, one word per cycle).
- REQ-024 SHALL hold C, S and CVld unchanged while CVld = 1 and CRdy = 0 (backpressure); ARdy = 0 in that state.
- REQ-025 SHALL keep an internal SW-bit round-robin pointer Ptr; on an input transfer in Mode 1 from channel i, Ptr <= i+1, wrapping N-1 -> 0 (also for non-power-of-two N).
- REQ-026 SHALL leave Ptr unchanged in Mode 0; a Mode change takes effect at the next grant evaluation and Ptr is retained.
- REQ-027 SHALL increment XferCnt by 1 on each output transfer, wrapping 255 -> 0.
- REQ-028 SHALL treat data on non-granted channels as don't-care; upstream channels SHALL hold data while AVld = 1 and ARdy = 0.

Reset
- REQ-029 SHALL, when Rst = 1 at a rising edge, set CVld = 0, C = 0, S = 0, Ptr = 0, XferCnt = 0; Rst overrides all transfers in that cycle.
- REQ-030 SHALL drive ARdy = 0 while Rst = 1; data held in C at reset mid-operation is discarded.

Verification (N=4, W=4)
- REQ-031 SHALL verify fixed priority: Mode=0, AVld=1111, A={D,C,B,A} (hex, ch3..ch0), CRdy=1 for 4 cycles -> C=A, S=0 every cycle; ARdy=0001; XferCnt=3 after 4 edges (first output valid after edge 1).
- REQ-032 SHALL verify round-robin: Mode=1, AVld=1111, same data, CRdy=1 -> S sequence 0,1,2,3,0; C sequence A,B,C,D,A.
- REQ-033 SHALL verify skipping: Mode=1, AVld=1010, CRdy=1 -> S sequence 1,3,1,3; ARdy[0] and ARdy[2] never 1.
- REQ-034 SHALL verify backpressure: Mode=1, AVld=1111, CRdy=0 for 3 cycles after the first load -> C, S, CVld constant, ARdy=0000, XferCnt unchanged; CRdy=1 resumes with S=1 next.
- REQ-035 SHALL verify reset mid-operation: Rst=1 for one edge while CVld=1, XferCnt=5, Ptr=2 -> CVld=0, C=0, S=0, XferCnt=0; next grant in Mode 1 with AVld=1111 is S=0.
- REQ-036 SHALL verify counter wrap: 256 consecutive output transfers -> XferCnt returns to 0.
